alu_seq_ctrl: RTL and testbench
===============================

Name: alu_seq_ctrl

Overview:
- Upstream sequencer for the 8-bit MiniCPU ALU.
- Accepts one instruction at a time over a valid/ready handshake and reads operands from a small internal register file.
- Drives the ALU's a/b/cin/sel inputs from registers, captures y, writes it back to the register file and presents it on a result handshake.
- Sits between the instruction source and the combinational ALU; owns the architectural register state.

Parameters:
- DW, 8, datapath width; must equal the ALU operand width.
- RA_W, 2, register-address width; the register file holds 2**RA_W entries.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- instr_valid  in  1  instruction available.
- instr_ready  out  1  block can accept an instruction.
- instr  in  20  [19:16] sel, [15] use_imm, [14] cin, [13:12] rd, [11:10] rs, [9] load, [8] reserved, [7:0] imm.
- alu_a  out  DW  operand a to the ALU.
- alu_b  out  DW  operand b to the ALU.
- alu_cin  out  1  carry-in to the ALU.
- alu_sel  out  4  operation select to the ALU.
- alu_y  in  DW  ALU result; combinational from alu_* outputs.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts the result.
- res_data  out  DW  written-back value.
- res_rd  out  RA_W  destination register of the result.
- dbg_addr  in  RA_W  debug read address.
- dbg_data  out  DW  combinational read of R[dbg_addr].

Behaviour:
- Reset (async, any state): state=IDLE; R[0..N-1]=0; alu_a=alu_b=0; alu_cin=0; alu_sel=0; res_valid=0; res_data=0; res_rd=0. instr_ready=1 once rst_n deasserts.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - instr_ready=1.
  - On the edge with instr_valid=1, latch the operands and go to EXEC:
    - alu_a <= R[rd]
    - alu_b <= use_imm ? imm : R[rs]
    - alu_cin <= cin
    - alu_sel <= sel
    - rd and load are latched.
- EXEC (exactly 1 cycle):
  - instr_ready=0; alu_* outputs held stable.
  - At the next edge: result = load ? imm : alu_y; R[rd] <= result; res_data <= result; res_rd <= rd; res_valid <= 1; go to WB.
- WB:
  - instr_ready=0; res_valid=1; res_data and res_rd held.
  - On the edge with res_ready=1: res_valid <= 0, go to IDLE.
  - res_ready=0 stalls indefinitely with no change to any output.
- Latency: accept edge to res_valid high = 2 edges. Best-case throughput is 1 instruction per 3 cycles (res_ready tied high).
- alu_* outputs keep their last values outside EXEC; they do not return to 0.
- Operand read-after-write: the register write at the end of EXEC always precedes the next accept, so no hazard is possible. rd == rs is legal and reads the old value.
- load=1: ALU output is ignored; alu_* are still driven as normal; use_imm, cin and sel are don't-care for the result.
- Reserved bit [8] is ignored.
- Width rules:
  - res_data is alu_y truncated to DW (it already is).
  - imm is zero-extended/truncated to DW.
- instr_valid while instr_ready=0 is ignored; the source must hold it (standard valid/ready).
- dbg_data reflects the register write from the cycle after the EXEC edge.
- rst_n asserted mid-EXEC or mid-WB: the in-flight instruction is dropped, no register write occurs, and res_valid clears immediately.

Decomposition:
- Shared package minicpu_pkg:
  - Instruction field bit positions.
  - State enum (IDLE/EXEC/WB).
  - ALU_OP_ADD=4'h7 constant.
  - Instruction width 20.
- One natural sub-module: minicpu_regfile.
  - 2**RA_W x DW, async reset to 0.
  - Two combinational read ports (rs/rd plus debug) and one synchronous write port.

Test Plan:
- Reset mid-stream: hold rst_n=0 during EXEC after accepting a load of 0x55 to R2 -> res_valid=0 immediately; after release dbg R2=0x00 and instr_ready=1.
- Load then ADD with carry, real ALU attached:
  - LOAD R0=0x93, then LOAD R1=0xA7 -> each res_data equals the immediate.
  - Then sel=7, use_imm=0, cin=1, rd=0, rs=1 -> during EXEC alu_a=0x93, alu_b=0xA7, alu_cin=1.
  - res_data=0x3B, res_rd=0, dbg R0=0x3B.
  - res_valid rises exactly 2 edges after accept.
- Immediate operand: R3=0x10, instr sel=7, use_imm=1, imm=0x05, cin=0, rd=3 -> alu_b=0x05, R3=0x15.
- Back-pressure: hold res_ready=0 for 5 cycles in WB -> res_valid, res_data and res_rd stable, instr_ready=0, and a new instr_valid is not accepted. Release -> IDLE one edge later.
- All 16 sel values with stubbed ALU (alu_y = {4'h0, alu_sel} ^ alu_a) -> alu_sel matches the instruction each time and written-back R[rd] equals the stub output.
- rd == rs: R2=0x80, sel=7, rs=rd=2, cin=0 -> alu_a=alu_b=0x80 and R2=0x00 (wrap-around).

Source files
------------

// File: rtl/minicpu_pkg.sv
// minicpu_pkg: shared instruction layout, sequencer states and ALU opcodes for the MiniCPU front end.
package minicpu_pkg;

    localparam int INSTR_W   = 20;
    localparam int F_SEL_HI  = 19;
    localparam int F_SEL_LO  = 16;
    localparam int F_USE_IMM = 15;
    localparam int F_CIN     = 14;
    localparam int F_RD_HI   = 13;
    localparam int F_RD_LO   = 12;
    localparam int F_RS_HI   = 11;
    localparam int F_RS_LO   = 10;
    localparam int F_LOAD    = 9;
    localparam int F_RSVD    = 8;
    localparam int F_IMM_HI  = 7;
    localparam int F_IMM_LO  = 0;

    localparam logic [3:0] ALU_OP_ADD = 4'h7;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

endpackage

// File: rtl/minicpu_regfile.sv
// minicpu_regfile: 2**RA_W x DW architectural registers, async clear, one write port,
// two operand read ports and one debug read port.
module minicpu_regfile #(
    parameter int DW   = 8,
    parameter int RA_W = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [RA_W-1:0] waddr,
    input  logic [DW-1:0]   wdata,
    input  logic [RA_W-1:0] ra_addr,
    output logic [DW-1:0]   ra_data,
    input  logic [RA_W-1:0] rb_addr,
    output logic [DW-1:0]   rb_data,
    input  logic [RA_W-1:0] dbg_addr,
    output logic [DW-1:0]   dbg_data
);

    logic [DW-1:0] mem [2**RA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2**RA_W; i++) mem[i] <= '0;
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign ra_data  = mem[ra_addr];
    assign rb_data  = mem[rb_addr];
    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: accepts one instruction at a time, drives the combinational ALU from registers,
// writes the result back to the register file and offers it on a result handshake.
module alu_seq_ctrl
    import minicpu_pkg::*;
#(
    parameter int DW   = 8,
    parameter int RA_W = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic [DW-1:0]      alu_a,
    output logic [DW-1:0]      alu_b,
    output logic               alu_cin,
    output logic [3:0]         alu_sel,
    input  logic [DW-1:0]      alu_y,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [DW-1:0]      res_data,
    output logic [RA_W-1:0]    res_rd,
    input  logic [RA_W-1:0]    dbg_addr,
    output logic [DW-1:0]      dbg_data
);

    state_t          state;
    logic [RA_W-1:0] rd_q;
    logic            load_q;
    logic [DW-1:0]   imm_q;
    logic [DW-1:0]   rd_val;
    logic [DW-1:0]   rs_val;
    logic [DW-1:0]   imm;
    logic [RA_W-1:0] rd;
    logic [RA_W-1:0] rs;
    logic [DW-1:0]   result;
    logic            unused_rsvd;

    assign imm         = DW'(instr[F_IMM_HI:F_IMM_LO]);
    assign rd          = RA_W'(instr[F_RD_HI:F_RD_LO]);
    assign rs          = RA_W'(instr[F_RS_HI:F_RS_LO]);
    assign unused_rsvd = instr[F_RSVD];
    assign result      = load_q ? imm_q : alu_y;
    assign instr_ready = rst_n && state == IDLE;

    minicpu_regfile #(.DW(DW), .RA_W(RA_W)) u_rf (
        .clk      (clk),
        .rst_n    (rst_n),
        .we       (state == EXEC),
        .waddr    (rd_q),
        .wdata    (result),
        .ra_addr  (rd),
        .ra_data  (rd_val),
        .rb_addr  (rs),
        .rb_data  (rs_val),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // The register write at the EXEC edge lands before IDLE can accept again, so no bypass is needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_cin   <= 1'b0;
            alu_sel   <= '0;
            rd_q      <= '0;
            load_q    <= 1'b0;
            imm_q     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_rd    <= '0;
        end else begin
            case (state)
                IDLE: if (instr_valid) begin
                    alu_a   <= rd_val;
                    alu_b   <= instr[F_USE_IMM] ? imm : rs_val;
                    alu_cin <= instr[F_CIN];
                    alu_sel <= instr[F_SEL_HI:F_SEL_LO];
                    rd_q    <= rd;
                    load_q  <= instr[F_LOAD];
                    imm_q   <= imm;
                    state   <= EXEC;
                end
                EXEC: begin
                    res_data  <= result;
                    res_rd    <= rd_q;
                    res_valid <= 1'b1;
                    state     <= WB;
                end
                WB: if (res_ready) begin
                    res_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed checks of alu_seq_ctrl with a bench-side ALU and a result scoreboard.
module tb_alu_seq_ctrl;
    import minicpu_pkg::*;

    typedef struct {
        logic [1:0] rd;
        logic [7:0] d;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [19:0] instr;
    logic [7:0]  alu_a;
    logic [7:0]  alu_b;
    logic        alu_cin;
    logic [3:0]  alu_sel;
    logic [7:0]  alu_y;
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_data;
    logic [1:0]  res_rd;
    logic [1:0]  dbg_addr;
    logic [7:0]  dbg_data;
    logic        stub;

    int   total;
    int   bad;
    exp_t sb[$];
    logic [7:0] reg_m [4];

    alu_seq_ctrl #(.DW(8), .RA_W(2)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_cin     (alu_cin),
        .alu_sel     (alu_sel),
        .alu_y       (alu_y),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_rd      (res_rd),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    assign alu_y = stub ? ({4'h0, alu_sel} ^ alu_a) : 8'(alu_a + alu_b + {7'b0, alu_cin});

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [19:0] mk(input logic [3:0] sel, input logic ui, input logic cin,
                                       input logic [1:0] rd, input logic [1:0] rs,
                                       input logic ld, input logic rsvd, input logic [7:0] imm);
        return {sel, ui, cin, rd, rs, ld, rsvd, imm};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] rd, input logic [7:0] d);
        exp_t e;
        e.rd = rd;
        e.d  = d;
        sb.push_back(e);
        reg_m[rd] = d;
    endtask

    // Drive at a falling edge; returns at the falling edge inside EXEC.
    task automatic send(input logic [19:0] ins);
        instr = ins;
        instr_valid = 1'b1;
        chk("accept_ready", {31'b0, instr_ready}, 1);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("exec_no_valid", {31'b0, res_valid}, 0);
        chk("exec_not_ready", {31'b0, instr_ready}, 0);
    endtask

    task automatic to_wb();
        @(negedge clk);
        chk("latency_valid", {31'b0, res_valid}, 1);
    endtask

    task automatic retire();
        exp_t e;
        assert (sb.size() > 0) else begin
            bad++;
            $error("FAIL sb_underflow observed=0 expected=1");
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("res_data", {24'b0, res_data}, {24'b0, e.d});
            chk("res_rd", {30'b0, res_rd}, {30'b0, e.rd});
            dbg_addr = e.rd;
            #1;
            chk("dbg_wb", {24'b0, dbg_data}, {24'b0, e.d});
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("idle_ready", {31'b0, instr_ready}, 1);
        chk("idle_no_valid", {31'b0, res_valid}, 0);
    endtask

    task automatic dbg(input string tag, input logic [1:0] a, input logic [7:0] exp);
        dbg_addr = a;
        #1;
        chk(tag, {24'b0, dbg_data}, {24'b0, exp});
    endtask

    initial begin
        logic [7:0] d0;
        logic [1:0] r0;
        logic [1:0] rd;
        logic [7:0] ex;
        total = 0;
        bad = 0;
        stub = 1'b0;
        rst_n = 1'b0;
        instr_valid = 1'b0;
        instr = '0;
        res_ready = 1'b0;
        dbg_addr = '0;
        for (int i = 0; i < 4; i++) reg_m[i] = 8'h00;

        repeat (2) @(negedge clk);
        chk("rst_res_valid", {31'b0, res_valid}, 0);
        chk("rst_alu_a", {24'b0, alu_a}, 0);
        chk("rst_res_data", {24'b0, res_data}, 0);
        chk("rst_alu_sel", {28'b0, alu_sel}, 0);
        rst_n = 1'b1;
        #1;
        chk("rst_release_ready", {31'b0, instr_ready}, 1);
        @(negedge clk);

        // Reset while EXEC holds a load of 0x55 into R2: nothing written.
        send(mk(4'h0, 1'b0, 1'b0, 2'd2, 2'd0, 1'b1, 1'b0, 8'h55));
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'b0, res_valid}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        dbg("midrst_r2", 2'd2, 8'h00);
        chk("midrst_ready", {31'b0, instr_ready}, 1);
        @(negedge clk);

        // Loads then ADD with carry.
        push(2'd0, 8'h93);
        send(mk(4'h0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b1, 1'b0, 8'h93));
        to_wb();
        retire();
        push(2'd1, 8'hA7);
        send(mk(4'h3, 1'b1, 1'b1, 2'd1, 2'd2, 1'b1, 1'b1, 8'hA7));
        to_wb();
        retire();
        push(2'd0, 8'h3B);
        send(mk(ALU_OP_ADD, 1'b0, 1'b1, 2'd0, 2'd1, 1'b0, 1'b0, 8'hFF));
        chk("add_alu_a", {24'b0, alu_a}, 32'h93);
        chk("add_alu_b", {24'b0, alu_b}, 32'hA7);
        chk("add_alu_cin", {31'b0, alu_cin}, 1);
        chk("add_alu_sel", {28'b0, alu_sel}, {28'b0, ALU_OP_ADD});
        to_wb();
        retire();
        dbg("add_r0", 2'd0, 8'h3B);
        chk("alu_hold_idle", {24'b0, alu_a}, 32'h93);

        // Immediate operand.
        push(2'd3, 8'h10);
        send(mk(4'h0, 1'b0, 1'b0, 2'd3, 2'd0, 1'b1, 1'b0, 8'h10));
        to_wb();
        retire();
        push(2'd3, 8'h15);
        send(mk(ALU_OP_ADD, 1'b1, 1'b0, 2'd3, 2'd0, 1'b0, 1'b0, 8'h05));
        chk("imm_alu_a", {24'b0, alu_a}, 32'h10);
        chk("imm_alu_b", {24'b0, alu_b}, 32'h05);
        to_wb();
        retire();
        dbg("imm_r3", 2'd3, 8'h15);

        // Back-pressure in WB with a competing instruction offered.
        push(2'd1, 8'h42);
        send(mk(4'h0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b1, 1'b0, 8'h42));
        to_wb();
        d0 = res_data;
        r0 = res_rd;
        instr = mk(4'h0, 1'b0, 1'b0, 2'd1, 2'd0, 1'b1, 1'b0, 8'hEE);
        instr_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_valid", {31'b0, res_valid}, 1);
            chk("bp_data", {24'b0, res_data}, {24'b0, d0});
            chk("bp_rd", {30'b0, res_rd}, {30'b0, r0});
            chk("bp_ready", {31'b0, instr_ready}, 0);
        end
        instr_valid = 1'b0;
        retire();
        dbg("bp_r1_kept", 2'd1, 8'h42);

        // All 16 operation selects through the stub ALU.
        stub = 1'b1;
        for (int s = 0; s < 16; s++) begin
            rd = 2'(s);
            ex = {4'h0, 4'(s)} ^ reg_m[rd];
            push(rd, ex);
            send(mk(4'(s), 1'b0, 1'(s >> 2), rd, 2'(s + 1), 1'b0, 1'b0, 8'(s * 17)));
            chk("stub_sel", {28'b0, alu_sel}, 32'(s));
            to_wb();
            retire();
        end
        stub = 1'b0;

        // rd == rs reads the old value and wraps.
        push(2'd2, 8'h80);
        send(mk(4'h0, 1'b0, 1'b0, 2'd2, 2'd0, 1'b1, 1'b0, 8'h80));
        to_wb();
        retire();
        push(2'd2, 8'h00);
        send(mk(ALU_OP_ADD, 1'b0, 1'b0, 2'd2, 2'd2, 1'b0, 1'b0, 8'h00));
        chk("same_alu_a", {24'b0, alu_a}, 32'h80);
        chk("same_alu_b", {24'b0, alu_b}, 32'h80);
        to_wb();
        retire();
        dbg("same_r2", 2'd2, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
